// File: rtl/riscv_pkg.sv
// ============================================================================
// riscv_pkg: shared arbiter state/owner types and default watchdog limit. Rev 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam int unsigned C_DEFAULT_TIMEOUT = 64;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// mem_port_arbiter_if: fetch, load/store and memory port bundle. Rev 1.0
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic                  if_err;
  logic [DATA_W-1:0]     if_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_be;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic                  d_err;
  logic [DATA_W-1:0]     d_rdata;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_be;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_W-1:0]     mem_rdata;

  // Arbiter side
  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_err, if_rdata,
    output d_gnt, d_rvalid, d_err, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  // Requester and memory side
  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata, d_be,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_err, if_rdata,
    input  d_gnt, d_rvalid, d_err, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter: round-robin fetch/LSU share of one memory port with watchdog. Rev 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = C_DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned      CNT_W      = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e          state_q;
  owner_e              last_owner_q;
  logic [CNT_W-1:0]    cnt_q;

  owner_e              w_winner;
  logic                w_fetch_win;
  logic                w_any_req;
  logic                w_idle;
  logic                w_wait;
  logic                w_drive;
  logic                w_take;
  logic                w_resp;
  logic                w_timeout;
  logic                w_done;
  logic                w_own_i;
  logic                w_own_d;
  logic                w_we;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W/8-1:0] w_be;

  always_comb begin
    w_winner = OWN_D;
    if (bus.if_req && bus.d_req) begin
      w_winner = (last_owner_q == OWN_I) ? OWN_D : OWN_I;
    end else if (bus.if_req) begin
      w_winner = OWN_I;
    end
  end

  // Outputs are forced quiet while reset is held, even mid-transaction
  assign w_fetch_win = (w_winner == OWN_I);
  assign w_any_req   = bus.if_req | bus.d_req;
  assign w_idle      = (state_q == IDLE) && !reset;
  assign w_wait      = (state_q != IDLE) && !reset;
  assign w_drive     = w_idle && w_any_req;
  assign w_take      = w_drive && bus.mem_gnt;
  assign w_resp      = w_wait && bus.mem_rvalid;
  assign w_timeout   = w_wait && !bus.mem_rvalid && (cnt_q == C_CNT_LAST);
  assign w_done      = w_resp | w_timeout;
  assign w_own_i     = (state_q == WAIT_I);
  assign w_own_d     = (state_q == WAIT_D);

  assign w_addr  = w_fetch_win ? bus.if_addr : bus.d_addr;
  assign w_wdata = w_fetch_win ? '0 : bus.d_wdata;
  assign w_be    = w_fetch_win ? '1 : bus.d_be;
  assign w_we    = !w_fetch_win && bus.d_we;

  assign bus.mem_req   = w_drive;
  assign bus.mem_we    = w_drive && w_we;
  assign bus.mem_addr  = w_drive ? w_addr  : '0;
  assign bus.mem_wdata = w_drive ? w_wdata : '0;
  assign bus.mem_be    = w_drive ? w_be    : '0;

  assign bus.if_gnt    = w_take && w_fetch_win;
  assign bus.d_gnt     = w_take && !w_fetch_win;

  assign bus.if_rvalid = w_done && w_own_i;
  assign bus.if_err    = w_timeout && w_own_i;
  assign bus.if_rdata  = (w_resp && w_own_i) ? bus.mem_rdata : '0;
  assign bus.d_rvalid  = w_done && w_own_d;
  assign bus.d_err     = w_timeout && w_own_d;
  assign bus.d_rdata   = (w_resp && w_own_d) ? bus.mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_owner_q <= OWN_D;
      cnt_q        <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (w_take) begin
            state_q      <= w_fetch_win ? WAIT_I : WAIT_D;
            last_owner_q <= w_winner;
            cnt_q        <= '0;
          end
        end
        WAIT_I, WAIT_D: begin
          cnt_q <= cnt_q + 1'b1;
          if (w_done) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter: vector table, corner sequences and random model check. Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int TO = 8;

  typedef struct packed {
    logic        rst;
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dwe;
    logic [31:0] da;
    logic [31:0] dwd;
    logic [3:0]  dbe;
    logic        mg;
    logic        mrv;
    logic [31:0] mrd;
  } in_t;

  typedef struct packed {
    logic        mreq;
    logic        mwe;
    logic [31:0] maddr;
    logic [31:0] mwd;
    logic [3:0]  mbe;
    logic        ig;
    logic        irv;
    logic        ierr;
    logic [31:0] ird;
    logic        dg;
    logic        drv;
    logic        derr;
    logic [31:0] drd;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t e;
  } vec_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  // Reference model: who owns the port (0 none, 1 fetch, 2 data), how long it has waited
  int m_owner;
  int m_age;
  int m_last;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running want done");
    $fatal(1);
  end

  function automatic vec_t V(input in_t i, input out_t e);
    vec_t r;
    r.i = i;
    r.e = e;
    return r;
  endfunction

  function automatic int winner(input in_t v);
    if (v.ir && v.dr) return (m_last == 2) ? 1 : 2;
    else if (v.ir)    return 1;
    else              return 2;
  endfunction

  function automatic out_t model_out(input in_t v);
    out_t o;
    logic fin;
    logic err;
    o = '0;
    if (!v.rst) begin
      if (m_owner == 0) begin
        if (v.ir || v.dr) begin
          o.mreq = 1'b1;
          if (winner(v) == 1) begin
            o.maddr = v.ia;
            o.mbe   = 4'hF;
            o.ig    = v.mg;
          end else begin
            o.maddr = v.da;
            o.mwe   = v.dwe;
            o.mwd   = v.dwd;
            o.mbe   = v.dbe;
            o.dg    = v.mg;
          end
        end
      end else begin
        err = !v.mrv && (m_age == TO - 1);
        fin = v.mrv || err;
        if (m_owner == 1) begin
          o.irv  = fin;
          o.ierr = err;
          o.ird  = v.mrv ? v.mrd : 32'h0;
        end else begin
          o.drv  = fin;
          o.derr = err;
          o.drd  = v.mrv ? v.mrd : 32'h0;
        end
      end
    end
    return o;
  endfunction

  function automatic void model_step(input in_t v);
    int w;
    if (v.rst) begin
      m_owner = 0;
      m_age   = 0;
      m_last  = 2;
    end else if (m_owner == 0) begin
      if ((v.ir || v.dr) && v.mg) begin
        w       = winner(v);
        m_owner = w;
        m_last  = w;
        m_age   = 0;
      end
    end else if (v.mrv || m_age == TO - 1) begin
      m_owner = 0;
    end else begin
      m_age = m_age + 1;
    end
  endfunction

  task automatic drive(input in_t v);
    reset         = v.rst;
    bus.if_req    = v.ir;
    bus.if_addr   = v.ia;
    bus.d_req     = v.dr;
    bus.d_we      = v.dwe;
    bus.d_addr    = v.da;
    bus.d_wdata   = v.dwd;
    bus.d_be      = v.dbe;
    bus.mem_gnt   = v.mg;
    bus.mem_rvalid= v.mrv;
    bus.mem_rdata = v.mrd;
  endtask

  function automatic out_t sample();
    out_t o;
    o.mreq  = bus.mem_req;
    o.mwe   = bus.mem_we;
    o.maddr = bus.mem_addr;
    o.mwd   = bus.mem_wdata;
    o.mbe   = bus.mem_be;
    o.ig    = bus.if_gnt;
    o.irv   = bus.if_rvalid;
    o.ierr  = bus.if_err;
    o.ird   = bus.if_rdata;
    o.dg    = bus.d_gnt;
    o.drv   = bus.d_rvalid;
    o.derr  = bus.d_err;
    o.drd   = bus.d_rdata;
    return o;
  endfunction

  // Request fields are only meaningful while a request is being offered
  task automatic chk(input string nm, input out_t a, input out_t e);
    out_t am;
    out_t em;
    am = a;
    em = e;
    if (!e.mreq) begin
      am.mwe = 1'b0; am.maddr = '0; am.mwd = '0; am.mbe = '0;
      em.mwe = 1'b0; em.maddr = '0; em.mwd = '0; em.mbe = '0;
    end
    total++;
    if (am !== em) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic apply(input in_t v, input out_t e, input string nm);
    out_t a;
    drive(v);
    @(negedge clk);
    a = sample();
    chk(nm, a, e);
    model_step(v);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];
  in_t  r;
  out_t ex;
  out_t prev;

  initial begin
    total = 0;
    bad   = 0;
    drive(in_t'{default: '0, rst: 1'b1});
    @(posedge clk);
    #1;

    // Fetch only
    tbl.push_back(V(in_t'{default: '0, rst: 1'b1, ir: 1'b1, dr: 1'b1, mg: 1'b1}, '0));
    tbl.push_back(V(in_t'{default: '0, ir: 1'b1, ia: 32'h100, mg: 1'b1},
                    out_t'{default: '0, mreq: 1'b1, maddr: 32'h100, mbe: 4'hF, ig: 1'b1}));
    tbl.push_back(V(in_t'{default: '0, mrv: 1'b1, mrd: 32'h00500093},
                    out_t'{default: '0, irv: 1'b1, ird: 32'h00500093}));
    // Contention from reset: I, D, I
    tbl.push_back(V(in_t'{default: '0, rst: 1'b1, ir: 1'b1, dr: 1'b1, mg: 1'b1}, '0));
    tbl.push_back(V(in_t'{default: '0, ir: 1'b1, ia: 32'h104, dr: 1'b1, dwe: 1'b1, da: 32'h200,
                          dwd: 32'hDEADBEEF, dbe: 4'hF, mg: 1'b1},
                    out_t'{default: '0, mreq: 1'b1, maddr: 32'h104, mbe: 4'hF, ig: 1'b1}));
    tbl.push_back(V(in_t'{default: '0, dr: 1'b1, dwe: 1'b1, da: 32'h200, dwd: 32'hDEADBEEF,
                          dbe: 4'hF, mg: 1'b1, mrv: 1'b1, mrd: 32'h11111111},
                    out_t'{default: '0, irv: 1'b1, ird: 32'h11111111}));
    tbl.push_back(V(in_t'{default: '0, ir: 1'b1, ia: 32'h108, dr: 1'b1, dwe: 1'b1, da: 32'h200,
                          dwd: 32'hDEADBEEF, dbe: 4'hF, mg: 1'b1},
                    out_t'{default: '0, mreq: 1'b1, mwe: 1'b1, maddr: 32'h200, mwd: 32'hDEADBEEF,
                           mbe: 4'hF, dg: 1'b1}));
    tbl.push_back(V(in_t'{default: '0, ir: 1'b1, ia: 32'h108, mrv: 1'b1, mrd: 32'h22222222},
                    out_t'{default: '0, drv: 1'b1, drd: 32'h22222222}));
    tbl.push_back(V(in_t'{default: '0, ir: 1'b1, ia: 32'h108, dr: 1'b1, da: 32'h204, dbe: 4'h3,
                          mg: 1'b1},
                    out_t'{default: '0, mreq: 1'b1, maddr: 32'h108, mbe: 4'hF, ig: 1'b1}));
    tbl.push_back(V(in_t'{default: '0, mrv: 1'b1, mrd: 32'h33333333},
                    out_t'{default: '0, irv: 1'b1, ird: 32'h33333333}));
    // mem_gnt low for 5 cycles: data (not last owner) held on the bus, no grant
    for (int k = 0; k < 6; k++) begin
      tbl.push_back(V(in_t'{default: '0, ir: 1'b1, ia: 32'h10C, dr: 1'b1, dwe: 1'b1, da: 32'h208,
                            dwd: 32'hCAFEF00D, dbe: 4'hC, mg: (k == 5)},
                      out_t'{default: '0, mreq: 1'b1, mwe: 1'b1, maddr: 32'h208,
                             mwd: 32'hCAFEF00D, mbe: 4'hC, dg: (k == 5)}));
    end
    tbl.push_back(V(in_t'{default: '0, ir: 1'b1, ia: 32'h10C, mrv: 1'b1, mrd: 32'h44444444},
                    out_t'{default: '0, drv: 1'b1, drd: 32'h44444444}));
    // Spurious rvalid while idle
    tbl.push_back(V(in_t'{default: '0, mrv: 1'b1, mrd: 32'h55555555}, '0));

    for (int k = 0; k < tbl.size(); k++) begin
      apply(tbl[k].i, tbl[k].e, $sformatf("vec[%0d]", k));
    end

    // Data load timeout, late rvalid ignored, next fetch granted
    apply(in_t'{default: '0, rst: 1'b1}, '0, "to_rst");
    apply(in_t'{default: '0, dr: 1'b1, da: 32'h300, dbe: 4'hF, mg: 1'b1},
          out_t'{default: '0, mreq: 1'b1, maddr: 32'h300, mbe: 4'hF, dg: 1'b1}, "to_gnt");
    for (int k = 0; k < TO - 1; k++) begin
      apply(in_t'{default: '0, mrd: 32'hFFFFFFFF}, '0, "to_wait");
    end
    apply(in_t'{default: '0, mrd: 32'hFFFFFFFF},
          out_t'{default: '0, drv: 1'b1, derr: 1'b1}, "to_err");
    apply(in_t'{default: '0, mrv: 1'b1, mrd: 32'h77777777}, '0, "to_late");
    apply(in_t'{default: '0, ir: 1'b1, ia: 32'h400, mg: 1'b1},
          out_t'{default: '0, mreq: 1'b1, maddr: 32'h400, mbe: 4'hF, ig: 1'b1}, "to_next");
    apply(in_t'{default: '0, mrv: 1'b1, mrd: 32'h12345678},
          out_t'{default: '0, irv: 1'b1, ird: 32'h12345678}, "to_resp");

    // Reset in WAIT_I aborts silently; last owner returns to D
    apply(in_t'{default: '0, ir: 1'b1, ia: 32'h500, mg: 1'b1},
          out_t'{default: '0, mreq: 1'b1, maddr: 32'h500, mbe: 4'hF, ig: 1'b1}, "rw_gnt");
    apply(in_t'{default: '0, rst: 1'b1, ir: 1'b1, dr: 1'b1, mg: 1'b1}, '0, "rw_rst");
    apply(in_t'{default: '0, mrv: 1'b1, mrd: 32'h66666666}, '0, "rw_late");
    apply(in_t'{default: '0, ir: 1'b1, ia: 32'h504, dr: 1'b1, dwe: 1'b1, da: 32'h600,
                dwd: 32'h1, dbe: 4'hF, mg: 1'b1},
          out_t'{default: '0, mreq: 1'b1, maddr: 32'h504, mbe: 4'hF, ig: 1'b1}, "rw_cont");
    apply(in_t'{default: '0, mrv: 1'b1, mrd: 32'h88888888},
          out_t'{default: '0, irv: 1'b1, ird: 32'h88888888}, "rw_resp");

    // Response arriving in the timeout cycle completes normally
    apply(in_t'{default: '0, ir: 1'b1, ia: 32'h700, mg: 1'b1},
          out_t'{default: '0, mreq: 1'b1, maddr: 32'h700, mbe: 4'hF, ig: 1'b1}, "tr_gnt");
    for (int k = 0; k < TO - 1; k++) begin
      apply(in_t'{default: '0}, '0, "tr_wait");
    end
    apply(in_t'{default: '0, mrv: 1'b1, mrd: 32'hABCD1234},
          out_t'{default: '0, irv: 1'b1, ird: 32'hABCD1234}, "tr_both");

    // Randomized traffic against the reference model
    r = '0;
    r.rst = 1'b1;
    apply(r, '0, "rnd_rst");
    r.rst = 1'b0;
    prev  = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!r.ir || prev.ig || $urandom_range(15) == 0) begin
        r.ir = 1'($urandom_range(1));
        r.ia = $urandom;
      end
      if (!r.dr || prev.dg || $urandom_range(15) == 0) begin
        r.dr  = 1'($urandom_range(1));
        r.dwe = 1'($urandom_range(1));
        r.da  = $urandom;
        r.dwd = $urandom;
        r.dbe = 4'($urandom);
      end
      r.mg  = 1'($urandom_range(1));
      r.mrv = ($urandom_range(3) == 0);
      r.mrd = $urandom;
      r.rst = ($urandom_range(127) == 0);
      ex = model_out(r);
      apply(r, ex, "rnd");
      prev = ex;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single memory port between the instruction fetch path and the load/store path. Each requester issues one request at a time; the arbiter grants one, tracks the single outstanding transaction, and routes the memory response back to its owner. When both request, the arbiter alternates between them round-robin. A watchdog ends a stuck transaction with an error so the core never hangs. It sits between the IFU/LSU and the memory model or bus.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 64, cycles allowed in a wait state before an error completion (≥2)

Ports:
- clk  in  1  core clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high
- if_req / if_addr  in  1 / ADDR_W  fetch request and word address
- if_gnt / if_rvalid / if_err  out  1 each  fetch grant, response valid, error flag
- if_rdata  out  DATA_W  fetched instruction
- d_req / d_we  in  1 / 1  data request and write enable
- d_addr / d_wdata / d_be  in  ADDR_W / DATA_W / DATA_W/8  data address, write data, byte enables
- d_gnt / d_rvalid / d_err  out  1 each  data grant, response valid (load data or store ack), error flag
- d_rdata  out  DATA_W  load data
- mem_req / mem_we / mem_addr / mem_wdata / mem_be  out  memory request bundle
- mem_gnt / mem_rvalid  in  1 / 1  memory accepts request / memory returns response
- mem_rdata  in  DATA_W  memory read data

## Operation
- State machine with three states: IDLE, WAIT_I, WAIT_D. Reset puts it in IDLE, sets last_owner to D, and clears the watchdog counter.
- IDLE, winner selection (combinational):
  - Only one request active: that requester wins.
  - Both active: the requester that is not last_owner wins.
- IDLE, request drive:
  - mem_req = if_req | d_req.
  - The mem_* bundle carries the winner's fields. A fetch drives we=0, be=all-ones, wdata=0.
  - The winner's gnt = mem_gnt. The loser's gnt = 0.
- On mem_gnt while mem_req=1: go to WAIT_I or WAIT_D, set last_owner to the winner, and clear the counter.
- WAIT_x:
  - mem_req=0 and both gnt outputs are 0. The counter increments every cycle.
  - On mem_rvalid: x_rvalid=1 and x_rdata=mem_rdata in that same cycle, then return to IDLE. A new grant is possible on the following cycle at the earliest.
  - If the counter reaches TIMEOUT-1 with no rvalid: x_rvalid=1, x_err=1, x_rdata=0, then go to IDLE.
- A mem_rvalid that arrives in IDLE (stale or spurious) is ignored.
- Requesters hold req and all request fields stable until gnt. A deasserted req before gnt withdraws the request, which is legal.
- Unrouted rdata outputs are 0. rvalid and err go only to the current owner.

## Timing
- Reset values of all outputs are 0. mem_req is 0 during reset.
- Grant is zero-latency: gnt appears in the same cycle as mem_gnt.
- Response is zero-latency: rvalid appears in the same cycle as mem_rvalid.
- Minimum transaction time is 2 cycles: grant in cycle N, response in N+1, next grant in N+2.
- Under continuous contention, grants alternate I, D, I, D. Neither requester waits more than one transaction.
- Reset during a wait state returns to IDLE. No rvalid or err is issued for the aborted transaction, and its late mem_rvalid is ignored.
- An rvalid in the same cycle as the timeout takes priority: it completes normally with err=0.

## Structure
- Shared package riscv_pkg holds:
  - the arbiter state enum (IDLE, WAIT_I, WAIT_D)
  - the owner enum (OWN_I, OWN_D)
  - a default TIMEOUT constant
- Single module with no sub-modules. The watchdog counter is inline, with width $clog2(TIMEOUT).

## Test plan
- Fetch only: if_addr=0x100, mem_gnt=1, and mem_rvalid one cycle later with rdata=0x00500093. Expect if_gnt in the grant cycle, if_rvalid with rdata=0x00500093 the next cycle, and d_* outputs all 0.
- Both request from reset: fetch is granted first, then data, then fetch again. Check d_addr=0x200, d_we=1, wdata=0xDEADBEEF, be=0xF on mem_* during the data grant.
- mem_gnt held low for 5 cycles: the winner stays fixed, its request fields are stable on mem_*, and no gnt is asserted until mem_gnt rises.
- Data load with no rvalid and TIMEOUT=8: d_rvalid=1, d_err=1, d_rdata=0 in the 8th wait cycle, then IDLE. A late mem_rvalid is ignored and the next fetch is granted normally.
- Reset asserted in WAIT_I: all outputs are 0 the next cycle. The late mem_rvalid produces no if_rvalid, and last_owner=D, so fetch wins the next contention.
- Response and timeout in the same cycle: rvalid=1, err=0, and rdata is passed through.
